ptp_piezo_responder: RTL and testbench
======================================

Name:
ptp_piezo_responder

Overview:
- Slave-side end of the single-wire piezo timestamp exchange.
- Receives a SYNC frame carrying the master timestamp T1 and timestamps its start edge with local RTC time (T2).
- After a fixed gap, transmits a reply frame carrying T2 and timestamps the reply start edge (T3).
- Sits between the slave board's piezo line pins and the rtc_0 time counter; the triple {T1,T2,T3} is exported to HPS-visible registers.

Parameters:
- BIT_CYCLES, 64, clock cycles per line bit (even, >=4).
- DATA_BITS, 32, payload bits per frame.
- REPLY_GAP, 256, idle cycles between the end of the received stop bit and the start of the reply start bit.
- SYNC_STAGES, 2, input synchronizer depth (>=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  responder armed; when 0, stays/returns to IDLE after the current frame.
- local_time  in  32  free-running local RTC count.
- piezo_interface_in  in  1  line from master, idle high, asynchronous.
- piezo_interface_out  out  1  line to master, idle high.
- time_data_master  out  32  last received T1.
- time_data_slave  out  32  T2, local time at the received start edge.
- tx_time  out  32  T3, local time at the first cycle the reply start bit is driven.
- sample_valid  out  1  one-cycle pulse when T1/T2/T3 are all updated.
- frame_error  out  1  one-cycle pulse on a bad stop bit.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: piezo_interface_out=1; all 32-bit outputs=0; sample_valid=0, frame_error=0, busy=0; FSM=IDLE; synchronizer flops=1.
- Input passes through SYNC_STAGES flops. A falling edge is detected on the synchronized signal. T2 latches local_time on the edge-detect cycle, giving a fixed SYNC_STAGES+1 cycle offset with no compensation.
- Frame format: start bit 0, DATA_BITS bits LSB first, stop bit 1. Each bit lasts BIT_CYCLES cycles.
- IDLE: on falling edge with enable=1, latch the T2 candidate into a shadow register and go to RX_START with bit counter=0 and cycle counter=0.
- RX_START: sample at cycle BIT_CYCLES/2-1.
  - Sample is 1: glitch; go to IDLE with no error pulse and outputs unchanged.
  - Sample is 0: go to RX_DATA.
- RX_DATA: sample every BIT_CYCLES cycles at mid-bit and shift into the shift register. After DATA_BITS samples, go to RX_STOP.
- RX_STOP: sample at mid-bit.
  - Sample is 0: pulse frame_error, discard the frame, go to IDLE. Outputs are not updated.
  - Sample is 1: go to GAP.
- GAP: wait until REPLY_GAP cycles have passed since the end of the stop bit. The counter starts at the mid-stop sample, so the total wait is BIT_CYCLES/2+REPLY_GAP cycles from the stop sample. Line activity during GAP is ignored. Then go to TX_START.
- TX_START: drive 0 for BIT_CYCLES. On the first cycle, latch local_time into the T3 shadow register.
- TX_DATA: shift out the shadow T2, LSB first, BIT_CYCLES per bit.
- TX_STOP: drive 1 for BIT_CYCLES, then go to DONE.
- DONE (1 cycle):
  - Copy shadows to time_data_master, time_data_slave and tx_time in the same cycle.
  - Pulse sample_valid, which is high in the same cycle the new values appear.
  - Go to IDLE.
- Receive input is ignored from TX_START through DONE, so self-echo is not re-triggered.
- enable deasserted mid-frame: the current exchange completes. A new exchange starts only if enable=1 at the IDLE edge.
- Asynchronous reset mid-frame: line returns high immediately; outputs clear.
- Counters are sized $clog2(BIT_CYCLES), $clog2(DATA_BITS+1) and $clog2(REPLY_GAP+BIT_CYCLES). They never wrap within a state.
- local_time wrap (0xFFFFFFFF to 0) needs no special handling; the value is latched as-is.

Test Plan:
- BIT_CYCLES=8, REPLY_GAP=16, local_time incrementing by 1 from 0x100, frame T1=0xA5A5_1234 with its start edge at local_time 0x200:
  - time_data_master=0xA5A51234.
  - time_data_slave=0x200+SYNC_STAGES+1.
  - Reply frame on piezo_interface_out decodes to the T2 value.
  - tx_time equals local_time on the first low cycle.
  - One sample_valid pulse.
- Frame with stop bit forced 0:
  - One frame_error pulse.
  - Outputs unchanged, no reply driven, busy drops.
- 2-cycle low glitch on idle line: returns to IDLE, no error, no reply, outputs unchanged.
- Payload 0xFFFFFFFF with local_time crossing 0xFFFFFFFF→0 during the exchange: correct T1, and T3 less than T2 numerically as latched.
- Assert reset_n low mid RX_DATA:
  - Outputs zero asynchronously, line high.
  - After release, a fresh frame is received correctly.
- enable=0 at the start edge: no reception. enable dropped mid-frame: the exchange completes and the next frame is ignored.

Source files
------------

// File: rtl/ptp_piezo_responder.sv
// Slave end of the single-wire piezo timestamp exchange: receives T1, stamps its
// start edge (T2), replies with T2 after a fixed gap and stamps the reply start (T3).
module ptp_piezo_responder #(
    parameter int BIT_CYCLES  = 64,
    parameter int DATA_BITS   = 32,
    parameter int REPLY_GAP   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] local_time,
    input  logic        piezo_interface_in,
    output logic        piezo_interface_out,
    output logic [31:0] time_data_master,
    output logic [31:0] time_data_slave,
    output logic [31:0] tx_time,
    output logic        sample_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int HALF = BIT_CYCLES / 2;
    localparam int CW   = $clog2(BIT_CYCLES);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int GW   = $clog2(REPLY_GAP + BIT_CYCLES);

    typedef enum logic [3:0] {
        IDLE, RX_START, RX_DATA, RX_STOP, GAP, TX_START, TX_DATA, TX_STOP, DONE
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   fall_reg;
    logic [CW-1:0]          cyc_reg;
    logic [BW-1:0]          bit_reg;
    logic [GW-1:0]          gap_reg;
    logic [DATA_BITS-1:0]   rx_shift_reg;
    logic [31:0]            t2_shadow_reg;
    logic [31:0]            t3_shadow_reg;
    logic [31:0]            tx_shift_reg;
    logic                   out_reg;
    logic [31:0]            t1_out_reg;
    logic [31:0]            t2_out_reg;
    logic [31:0]            t3_out_reg;
    logic                   valid_reg;
    logic                   error_reg;
    logic                   line;

    // Synchronizer chain; flops idle high so a reset never fakes a start edge.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= piezo_interface_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign line = sync_reg[SYNC_STAGES-1];

    // Registered edge detect: T2 is stamped SYNC_STAGES+1 cycles after the line falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= 1'b1;
            fall_reg <= 1'b0;
        end else begin
            prev_reg <= line;
            fall_reg <= prev_reg & ~line;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cyc_reg       <= '0;
            bit_reg       <= '0;
            gap_reg       <= '0;
            rx_shift_reg  <= '0;
            t2_shadow_reg <= '0;
            t3_shadow_reg <= '0;
            tx_shift_reg  <= '0;
            out_reg       <= 1'b1;
            t1_out_reg    <= '0;
            t2_out_reg    <= '0;
            t3_out_reg    <= '0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fall_reg && enable) begin
                        t2_shadow_reg <= local_time;
                        cyc_reg       <= '0;
                        bit_reg       <= '0;
                        state_reg     <= RX_START;
                    end
                end
                RX_START: begin
                    if (cyc_reg == CW'(HALF - 1)) begin
                        cyc_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= line ? IDLE : RX_DATA;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cyc_reg == CW'(BIT_CYCLES - 1)) begin
                        cyc_reg      <= '0;
                        rx_shift_reg <= {line, rx_shift_reg[DATA_BITS-1:1]};
                        if (bit_reg == BW'(DATA_BITS - 1)) begin
                            bit_reg   <= '0;
                            state_reg <= RX_STOP;
                        end else begin
                            bit_reg <= bit_reg + BW'(1);
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cyc_reg == CW'(BIT_CYCLES - 1)) begin
                        cyc_reg <= '0;
                        if (line) begin
                            gap_reg   <= '0;
                            state_reg <= GAP;
                        end else begin
                            error_reg <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                GAP: begin
                    // Counted from the mid-stop sample, hence the extra half bit.
                    if (gap_reg == GW'(HALF + REPLY_GAP - 1)) begin
                        out_reg      <= 1'b0;
                        cyc_reg      <= '0;
                        tx_shift_reg <= t2_shadow_reg;
                        state_reg    <= TX_START;
                    end else begin
                        gap_reg <= gap_reg + GW'(1);
                    end
                end
                TX_START: begin
                    if (cyc_reg == '0) begin
                        t3_shadow_reg <= local_time;
                    end
                    if (cyc_reg == CW'(BIT_CYCLES - 1)) begin
                        cyc_reg      <= '0;
                        bit_reg      <= '0;
                        out_reg      <= tx_shift_reg[0];
                        tx_shift_reg <= tx_shift_reg >> 1;
                        state_reg    <= TX_DATA;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (cyc_reg == CW'(BIT_CYCLES - 1)) begin
                        cyc_reg <= '0;
                        if (bit_reg == BW'(DATA_BITS - 1)) begin
                            out_reg   <= 1'b1;
                            state_reg <= TX_STOP;
                        end else begin
                            bit_reg      <= bit_reg + BW'(1);
                            out_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= tx_shift_reg >> 1;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (cyc_reg == CW'(BIT_CYCLES - 1)) begin
                        cyc_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                DONE: begin
                    t1_out_reg <= 32'(rx_shift_reg);
                    t2_out_reg <= t2_shadow_reg;
                    t3_out_reg <= t3_shadow_reg;
                    valid_reg  <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign piezo_interface_out = out_reg;
    assign time_data_master    = t1_out_reg;
    assign time_data_slave     = t2_out_reg;
    assign tx_time             = t3_out_reg;
    assign sample_valid        = valid_reg;
    assign frame_error         = error_reg;
    assign busy                = (state_reg != IDLE);

endmodule

// File: tb/tb_ptp_piezo_responder.sv
// Scoreboard bench for ptp_piezo_responder: stimulus pushes expected events, a
// monitor pops them on sample_valid/frame_error, a decoder captures the reply frame.
module tb_ptp_piezo_responder;

    localparam int BIT = 8;
    localparam int DB  = 32;
    localparam int RG  = 16;
    localparam int SS  = 2;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] local_time = 32'h100;
    logic        piezo_in = 1'b1;
    logic        piezo_out;
    logic [31:0] time_data_master;
    logic [31:0] time_data_slave;
    logic [31:0] tx_time;
    logic        sample_valid;
    logic        frame_error;
    logic        busy;

    logic        lt_jump = 1'b0;
    logic [31:0] lt_jump_val = '0;

    typedef struct {
        bit          is_err;
        logic [31:0] t1;
        logic [31:0] t2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        ev;
    int          errors = 0;
    int          checks = 0;
    int          n_events = 0;
    int          n_valid = 0;
    int          exp_events = 0;
    int          exp_replies = 0;
    int          reply_count = 0;
    logic [31:0] reply_word = '0;
    logic [31:0] t3_obs = '0;
    logic [31:0] last_t1 = '0;
    logic [31:0] last_t2 = '0;
    logic [31:0] last_t3 = '0;

    ptp_piezo_responder #(
        .BIT_CYCLES (BIT),
        .DATA_BITS  (DB),
        .REPLY_GAP  (RG),
        .SYNC_STAGES(SS)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .local_time         (local_time),
        .piezo_interface_in (piezo_in),
        .piezo_interface_out(piezo_out),
        .time_data_master   (time_data_master),
        .time_data_slave    (time_data_slave),
        .tx_time            (tx_time),
        .sample_valid       (sample_valid),
        .frame_error        (frame_error),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) local_time <= lt_jump ? lt_jump_val : local_time + 32'd1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Drives a full frame starting at the current negedge; records the expectation first.
    task automatic exchange(input logic [31:0] d, input logic stop_v, input int kind);
        logic [31:0] start_lt;
        exp_t        e;
        start_lt = local_time;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.t1     = d;
            e.t2     = start_lt + 32'(SS + 1);
            sb_q.push_back(e);
            exp_events++;
            if (kind == K_VALID) exp_replies++;
        end
        $display("send frame d=0x%08h stop=%0b start_lt=0x%08h kind=%0d", d, stop_v, start_lt, kind);
        piezo_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < DB; k++) begin
            piezo_in = d[k];
            repeat (BIT) @(negedge clk);
        end
        piezo_in = stop_v;
        repeat (BIT) @(negedge clk);
        piezo_in = 1'b1;
    endtask

    task automatic wait_events(input int target, input int budget);
        for (int i = 0; i < budget && n_events < target; i++) @(negedge clk);
        if (n_events < target) fail_now("event_timeout", $sformatf("saw %0d events, wanted %0d", n_events, target));
    endtask

    task automatic check_quiet(input string tag);
        check32({tag, "_events"}, n_events, exp_events);
        check32({tag, "_replies"}, reply_count, exp_replies);
        check32({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check32({tag, "_t1"}, time_data_master, last_t1);
        check32({tag, "_t2"}, time_data_slave, last_t2);
        check32({tag, "_t3"}, tx_time, last_t3);
    endtask

    // Reply decoder: mid-bit sampling relative to the first low cycle.
    initial begin : decoder
        logic        prev_o;
        logic [31:0] w;
        logic [31:0] t3_cap;
        logic        start_v;
        logic        stop_v;
        prev_o = 1'b1;
        w = '0;
        forever begin
            @(negedge clk);
            if (reset_n && piezo_out === 1'b0 && prev_o === 1'b1) begin
                t3_cap = local_time;
                repeat (BIT / 2) @(negedge clk);
                start_v = piezo_out;
                for (int k = 0; k < DB; k++) begin
                    repeat (BIT) @(negedge clk);
                    w[k] = piezo_out;
                end
                repeat (BIT) @(negedge clk);
                stop_v = piezo_out;
                check32("reply_start_bit", {31'd0, start_v}, 32'd0);
                check32("reply_stop_bit", {31'd0, stop_v}, 32'd1);
                t3_obs      = t3_cap;
                reply_word  = w;
                reply_count = reply_count + 1;
                $display("reply word=0x%08h first_low_lt=0x%08h", w, t3_cap);
            end
            prev_o = piezo_out;
        end
    end

    // Monitor: every sample_valid / frame_error cycle consumes one expectation.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n && (sample_valid || frame_error)) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_event", $sformatf("valid=%0b error=%0b with nothing expected", sample_valid, frame_error));
                end else begin
                    ev = sb_q.pop_front();
                    check32("event_error_flag", {31'd0, frame_error}, {31'd0, ev.is_err});
                    check32("event_valid_flag", {31'd0, sample_valid}, {31'd0, !ev.is_err});
                    if (!ev.is_err) begin
                        check32("t1", time_data_master, ev.t1);
                        check32("t2", time_data_slave, ev.t2);
                        check32("t3_vs_first_low", tx_time, t3_obs);
                        check32("reply_payload", reply_word, ev.t2);
                        check32("reply_count", reply_count, n_valid + 1);
                        n_valid++;
                        last_t1 = ev.t1;
                        last_t2 = ev.t2;
                        last_t3 = t3_obs;
                        $display("valid t1=0x%08h t2=0x%08h t3=0x%08h", time_data_master, time_data_slave, tx_time);
                    end else begin
                        check32("err_t1_kept", time_data_master, last_t1);
                        check32("err_t2_kept", time_data_slave, last_t2);
                        check32("err_t3_kept", tx_time, last_t3);
                        $display("frame_error t1=0x%08h", time_data_master);
                    end
                end
                n_events++;
            end
        end
    end

    initial begin : stimulus
        repeat (5) @(negedge clk);
        check32("rst_line", {31'd0, piezo_out}, 32'd1);
        check32("rst_t1", time_data_master, 32'd0);
        check32("rst_t2", time_data_slave, 32'd0);
        check32("rst_t3", tx_time, 32'd0);
        check32("rst_valid", {31'd0, sample_valid}, 32'd0);
        check32("rst_error", {31'd0, frame_error}, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Basic exchange with the start edge at local_time 0x200.
        for (int i = 0; i < 1000 && local_time != 32'h200; i++) @(negedge clk);
        if (local_time != 32'h200) fail_now("align_0x200", "local_time never reached 0x200");
        exchange(32'hA5A5_1234, 1'b1, K_VALID);
        check32("busy_in_gap", {31'd0, busy}, 32'd1);
        wait_events(exp_events, 800);
        check32("t2_abs", time_data_slave, 32'h200 + 32'(SS + 1));
        repeat (3) @(negedge clk);
        check32("busy_after_done", {31'd0, busy}, 32'd0);

        // Bad stop bit.
        repeat (10) @(negedge clk);
        exchange(32'h0F0F_00FF, 1'b0, K_ERR);
        wait_events(exp_events, 200);
        repeat (400) @(negedge clk);
        check_quiet("stop_err");

        // Two-cycle glitch on an idle line.
        piezo_in = 1'b0;
        repeat (2) @(negedge clk);
        piezo_in = 1'b1;
        repeat (400) @(negedge clk);
        check_quiet("glitch");

        // All-ones payload with local_time wrapping before the reply.
        lt_jump_val = 32'hFFFF_FF80;
        lt_jump = 1'b1;
        @(negedge clk);
        lt_jump = 1'b0;
        exchange(32'hFFFF_FFFF, 1'b1, K_VALID);
        wait_events(exp_events, 800);
        checks++;
        if (!(tx_time < last_t2)) begin
            errors++;
            $display("FAIL wrap_t3_below_t2: got t3=0x%08h expected below t2=0x%08h", tx_time, last_t2);
        end

        // Asynchronous reset in the middle of RX_DATA.
        repeat (10) @(negedge clk);
        piezo_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            piezo_in = k[0];
            repeat (BIT) @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        check32("mid_rst_line", {31'd0, piezo_out}, 32'd1);
        check32("mid_rst_t1", time_data_master, 32'd0);
        check32("mid_rst_t2", time_data_slave, 32'd0);
        check32("mid_rst_t3", tx_time, 32'd0);
        check32("mid_rst_busy", {31'd0, busy}, 32'd0);
        last_t1 = '0;
        last_t2 = '0;
        last_t3 = '0;
        piezo_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        exchange(32'h1357_9BDF, 1'b1, K_VALID);
        wait_events(exp_events, 800);

        // Disabled at the start edge.
        repeat (10) @(negedge clk);
        enable = 1'b0;
        exchange(32'h2222_2222, 1'b1, K_NONE);
        repeat (400) @(negedge clk);
        check_quiet("disabled");

        // Enable dropped mid-frame: exchange completes, next frame ignored.
        enable = 1'b1;
        fork
            exchange(32'h5A5A_A5A5, 1'b1, K_VALID);
            begin
                repeat (60) @(negedge clk);
                enable = 1'b0;
            end
        join
        wait_events(exp_events, 800);
        repeat (10) @(negedge clk);
        exchange(32'h7777_7777, 1'b1, K_NONE);
        repeat (400) @(negedge clk);
        check_quiet("after_disable");

        check32("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
